// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the multi-port register file.
//   rf_state_e : clear-engine state (IDLE, CLEAR)
//   calc_aw()  : address width for a given entry count
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_e;

  // A one-entry address would be zero bits wide, so the width is never below 1.
  function automatic int calc_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one pending bit per register entry.
//   i_flush              : synchronous clear of every bit
//   i_set_en/i_set_addr  : mark an entry pending (issue)
//   i_clr_en/i_clr_addr  : mark an entry resolved (writeback); also masks
//                          the lookup combinationally in the same cycle
//   i_rd_addr            : NUM_READ packed lookup addresses
//   o_rd_pending         : per-lookup pending flag
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2,
  localparam int AW      = calc_aw(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_flush,
  input  logic                   i_set_en,
  input  logic [AW-1:0]          i_set_addr,
  input  logic                   i_clr_en,
  input  logic [AW-1:0]          i_clr_addr,
  input  logic [NUM_READ*AW-1:0] i_rd_addr,
  output logic [NUM_READ-1:0]    o_rd_pending
);

  logic [DEPTH-1:0] r_bits;

  // Set is written after clear so an issue and a write to the same entry
  // in one cycle leave the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bits <= '0;
    end else if (i_flush) begin
      r_bits <= '0;
    end else begin
      if (i_clr_en) r_bits[i_clr_addr] <= 1'b0;
      if (i_set_en) r_bits[i_set_addr] <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_READ; g++) begin : g_lookup
    logic [AW-1:0] w_addr;
    assign w_addr          = i_rd_addr[g*AW +: AW];
    assign o_rd_pending[g] = r_bits[w_addr] && !(i_clr_en && (i_clr_addr == w_addr));
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file.
//   clk, reset_n            : clock, async active-low reset
//   write_en/addr/data      : writeback port (ignored while clearing)
//   issue_en/issue_addr     : mark an entry as awaiting writeback
//   read_addr/read_data     : NUM_READ packed combinational read ports with
//                             same-cycle write bypass
//   read_pending            : per-port outstanding-write flag
//   clear_req/clear_busy    : start / status of the one-entry-per-cycle clear
//   dbg_state               : current clear-engine state (1 = CLEAR)
// Handshake: there is no back-pressure. write_en/issue_en are single-cycle
// strobes accepted on any edge where clear_busy is low; clear_req is sampled
// only while idle and is dropped while a clear is running.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = calc_aw(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      write_en,
  input  logic [AW-1:0]             write_addr,
  input  logic [WIDTH-1:0]          write_data,
  input  logic                      issue_en,
  input  logic [AW-1:0]             issue_addr,
  input  logic [NUM_READ*AW-1:0]    read_addr,
  output logic [NUM_READ*WIDTH-1:0] read_data,
  output logic [NUM_READ-1:0]       read_pending,
  input  logic                      clear_req,
  output logic                      clear_busy,
  output logic                      dbg_state
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam bit            ZR       = (ZERO_REG != 0);

  rf_state_e        r_state;
  rf_state_e        w_state_nxt;
  logic [AW-1:0]    r_clr_idx;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic                w_busy;
  logic                w_start;
  logic                w_wr_ok;
  logic                w_iss_ok;
  logic [NUM_READ-1:0] w_sb_pend;

  assign w_busy     = (r_state == CLEAR);
  assign w_start    = !w_busy && clear_req;
  // Writes and issues to the hardwired-zero entry are dropped here so the
  // entry never holds data and never becomes pending.
  assign w_wr_ok    = !w_busy && write_en && !(ZR && (write_addr == '0));
  assign w_iss_ok   = !w_busy && issue_en && !(ZR && (issue_addr == '0));
  assign clear_busy = w_busy;
  assign dbg_state  = r_state;

  // Clear engine state register and index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_busy)       r_clr_idx <= r_clr_idx + AW'(1);
      else if (w_start) r_clr_idx <= '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (clear_req) w_state_nxt = CLEAR;
      CLEAR:   if (r_clr_idx == LAST_IDX) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Storage has no reset: its contents are made known by the clear engine.
  always_ff @(posedge clk) begin
    if (w_busy)       r_mem[r_clr_idx]  <= '0;
    else if (w_wr_ok) r_mem[write_addr] <= write_data;
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .NUM_READ (NUM_READ)
  ) u_scoreboard (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_flush      (w_start),
    .i_set_en     (w_iss_ok),
    .i_set_addr   (issue_addr),
    .i_clr_en     (w_wr_ok),
    .i_clr_addr   (write_addr),
    .i_rd_addr    (read_addr),
    .o_rd_pending (w_sb_pend)
  );

  for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_force_zero;
    logic          w_bypass;
    assign w_ra         = read_addr[g*AW +: AW];
    assign w_force_zero = w_busy || (ZR && (w_ra == '0));
    assign w_bypass     = w_wr_ok && (write_addr == w_ra);
    assign read_data[g*WIDTH +: WIDTH] = w_force_zero ? '0 :
                                         w_bypass     ? write_data :
                                                        r_mem[w_ra];
    assign read_pending[g] = !w_busy && w_sb_pend[g];
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int W = 66;  // {exp_d0, exp_d1, exp_p0, exp_p1}

  logic        clk;
  logic        reset_n;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [9:0]  read_addr;
  logic [63:0] read_data;
  logic [1:0]  read_pending;
  logic        clear_req;
  logic        clear_busy;
  logic        dbg_state;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic        ep0;
    logic        ep1;
  } vec_t;

  logic [W-1:0] exp_q[$];
  vec_t         vecs[12];
  int           n_checks;
  int           n_errors;
  int           n;
  logic [31:0]  m_mem[32];
  logic         m_sb[32];

  regfile_mp #(
    .WIDTH    (32),
    .DEPTH    (32),
    .NUM_READ (2),
    .ZERO_REG (1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .write_en     (write_en),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .issue_en     (issue_en),
    .issue_addr   (issue_addr),
    .read_addr    (read_addr),
    .read_data    (read_data),
    .read_pending (read_pending),
    .clear_req    (clear_req),
    .clear_busy   (clear_busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic zero_inputs();
    write_en   = 1'b0;
    write_addr = '0;
    write_data = '0;
    issue_en   = 1'b0;
    issue_addr = '0;
    clear_req  = 1'b0;
  endtask

  // Let any pending strobe commit, then drop all strobes.
  task automatic settle();
    @(posedge clk);
    #1;
    zero_inputs();
  endtask

  // Drive one vector after an edge, compare combinational outputs mid-cycle.
  task automatic apply(input vec_t v);
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    write_en   = v.we;
    write_addr = v.wa;
    write_data = v.wd;
    issue_en   = v.ie;
    issue_addr = v.ia;
    read_addr  = {v.ra1, v.ra0};
    exp_q.push_back({v.ed0, v.ed1, v.ep0, v.ep1});
    @(negedge clk);
    e = exp_q.pop_front();
    check("rd0", read_data[31:0], e[65:34]);
    check("rd1", read_data[63:32], e[33:2]);
    check("pend0", 32'(read_pending[0]), 32'(e[1]));
    check("pend1", 32'(read_pending[1]), 32'(e[0]));
  endtask

  // Count cycles with clear_busy high, starting from the current point.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (clear_busy && cnt < 100) begin
      cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  // Read every entry on both ports: all zero and not pending.
  task automatic sweep_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      read_addr = {5'(31 - a), 5'(a)};
      #1;
      check({tag, "_rd0"}, read_data[31:0], 32'h0);
      check({tag, "_rd1"}, read_data[63:32], 32'h0);
      check({tag, "_pend"}, 32'(read_pending), 32'h0);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    zero_inputs();
    read_addr = {5'd7, 5'd5};

    // Stimulus table: inputs then expected {rd0, rd1, pend0, pend1}.
    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd7, 32'hDEADBEEF, 32'h0,       1'b0, 1'b0};
    vecs[1]  = '{1'b1, 5'd7, 32'h00001234, 1'b0, 5'd0, 5'd5, 5'd7, 32'hDEADBEEF, 32'h1234,    1'b0, 1'b0};
    vecs[2]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd7, 32'h0,        32'h1234,    1'b0, 1'b0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd3, 32'h0,        32'h0,       1'b0, 1'b0};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd5, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 5'd3, 32'h00000033, 1'b0, 5'd0, 5'd3, 5'd3, 32'h33,       32'h33,      1'b0, 1'b0};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd0, 32'h33,       32'h0,       1'b0, 1'b0};
    vecs[8]  = '{1'b1, 5'd3, 32'h00000044, 1'b1, 5'd3, 5'd3, 5'd9, 32'h44,       32'h0,       1'b0, 1'b0};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h44,       32'h44,      1'b1, 1'b1};
    vecs[10] = '{1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd9, 5'd3, 32'hA5A5A5A5, 32'h44,      1'b0, 1'b1};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd3, 32'hA5A5A5A5, 32'h44,      1'b0, 1'b1};

    // Reset values while reset_n is held low.
    #12;
    check("rst_busy", 32'(clear_busy), 32'h1);
    check("rst_pend", 32'(read_pending), 32'h0);
    check("rst_rd", read_data[31:0], 32'h0);
    #11;
    reset_n = 1'b1;
    count_busy(n);
    check("rst_clear_len", 32'(n), 32'd32);
    check("idle_state", 32'(dbg_state), 32'h0);
    sweep_zero("post_rst");

    // Table-driven write/read, bypass, zero register, scoreboard.
    for (int i = 0; i < 12; i++) apply(vecs[i]);
    settle();

    // Clear request mid-operation; writes and a second request during busy.
    clear_req = 1'b1;
    read_addr = {5'd3, 5'd9};
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    check("clr_busy", 32'(clear_busy), 32'h1);
    n = 0;
    while (clear_busy && n < 100) begin
      n++;
      if (n == 3) begin
        check("clr_rd_forced", read_data[31:0], 32'h0);
        check("clr_pend_forced", 32'(read_pending), 32'h0);
      end
      write_en   = (n == 20);
      write_addr = 5'd9;
      write_data = 32'h00000077;
      issue_en   = (n == 21);
      issue_addr = 5'd9;
      clear_req  = (n == 25);
      @(posedge clk);
      #1;
    end
    zero_inputs();
    check("clr_len", 32'(n), 32'd32);
    #1;
    check("clr_entry9", read_data[31:0], 32'h0);
    check("clr_pend", 32'(read_pending), 32'h0);

    // Randomised traffic against a reference model (array now all zero).
    for (int a = 0; a < 32; a++) begin
      m_mem[a] = '0;
      m_sb[a]  = 1'b0;
    end
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v.we  = 1'($urandom_range(0, 1));
      v.wa  = 5'($urandom_range(0, 7));
      v.wd  = $urandom();
      v.ie  = ($urandom_range(0, 2) == 0);
      v.ia  = 5'($urandom_range(0, 7));
      v.ra0 = 5'($urandom_range(0, 7));
      v.ra1 = 5'($urandom_range(0, 7));
      v.ed0 = (v.ra0 == 0) ? 32'h0 : (v.we && v.wa == v.ra0) ? v.wd : m_mem[v.ra0];
      v.ed1 = (v.ra1 == 0) ? 32'h0 : (v.we && v.wa == v.ra1) ? v.wd : m_mem[v.ra1];
      v.ep0 = m_sb[v.ra0] && !(v.we && v.wa == v.ra0);
      v.ep1 = m_sb[v.ra1] && !(v.we && v.wa == v.ra1);
      apply(v);
      if (v.we && v.wa != 0) begin
        m_mem[v.wa] = v.wd;
        m_sb[v.wa]  = 1'b0;
      end
      if (v.ie && v.ia != 0) m_sb[v.ia] = 1'b1;
    end
    settle();

    // Async reset in the middle of normal operation: busy rises without an edge.
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_idle_busy", 32'(clear_busy), 32'h1);
    check("arst_idle_pend", 32'(read_pending), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    count_busy(n);
    check("arst_idle_len", 32'(n), 32'd32);
    sweep_zero("post_arst");

    // Async reset with the clear engine at index 10: full clear restarts.
    settle();
    write_en   = 1'b1;
    write_addr = 5'd20;
    write_data = 32'h0BADF00D;
    settle();
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_clr_busy", 32'(clear_busy), 32'h1);
    check("arst_clr_state", 32'(dbg_state), 32'h1);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    count_busy(n);
    check("arst_clr_len", 32'(n), 32'd32);
    sweep_zero("post_arst_clr");

    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL exp_q_drain: got %0d leftover entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
